// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencing controller for the 3-stage RNBIP-2 core
// (fetch/CCG1, decode/CCG2, execute/CCG3).
//
// Derives PC enable, IF/ID hold, ID/EX bubble and IF/ID flush from
// load-use / stack-pointer interlocks, execute-stage redirects and a debug
// halt/single-step port.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   id_*                  decode-stage operand usage and addresses
//   ex_*                  execute-stage write-back, load, SP and redirect info
//   dbg_halt, dbg_step    debug halt level and single-step request (rising edge)
//   pc_en, ifid_en        PC advance/load enable, IF/ID load enable
//   idex_bubble           load NOP into ID/EX
//   ifid_flush            clear IF/ID to NOP
//   halted                core frozen by debug
//   state                 FSM state code (RUN=0 LSTALL=1 FLUSH=2 HALT=3 STEP=4)
//   stall_cnt             saturating count of non-halt stall cycles
module pipe_hazard_ctrl #(
    parameter int unsigned RA_W         = 3,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_ra_use,
    input  logic [RA_W-1:0]  id_ra,
    input  logic             id_rb_use,
    input  logic [RA_W-1:0]  id_rb,
    input  logic             id_sp_use,
    input  logic             ex_valid,
    input  logic             ex_we,
    input  logic [RA_W-1:0]  ex_wa,
    input  logic             ex_load,
    input  logic             ex_sp_wr,
    input  logic             ex_redirect,
    input  logic             dbg_halt,
    input  logic             dbg_step,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        LSTALL = 3'd1,
        FLUSH  = 3'd2,
        HALT   = 3'd3,
        STEP   = 3'd4
    } state_t;

    // Extra cycles spent in FLUSH/LSTALL beyond the detecting cycle, minus one
    // (the counter exits when it reads zero).
    localparam logic [1:0] FLUSH_LD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
    localparam logic [1:0] LOAD_LD  = (LOAD_LAT > 1)     ? 2'(LOAD_LAT - 2)     : 2'd0;

    state_t     st, st_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       ret_flag, ret_nxt;
    logic       dbg_step_q;

    logic hz_load, hz_sp, hz, step_rise;
    logic pc_i, ifid_i, bub_i, flush_i, halt_i, resolve;

    assign hz_load = id_valid & ex_valid & ex_we & ex_load &
                     ((id_ra_use & (id_ra == ex_wa)) | (id_rb_use & (id_rb == ex_wa)));
    assign hz_sp   = id_valid & ex_valid & ex_sp_wr & id_sp_use;
    assign hz      = hz_load | hz_sp;

    assign step_rise = dbg_step & ~dbg_step_q;

    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        ret_nxt = ret_flag;
        pc_i    = 1'b0;
        ifid_i  = 1'b0;
        bub_i   = 1'b1;
        flush_i = 1'b0;
        halt_i  = 1'b0;
        resolve = 1'b0;

        case (st)
            RUN, STEP: begin
                // Redirect outranks a hazard: the dependent instruction is flushed anyway.
                if (ex_redirect) begin
                    pc_i    = 1'b1;
                    flush_i = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        st_nxt  = FLUSH;
                        cnt_nxt = FLUSH_LD;
                    end else begin
                        resolve = 1'b1;
                    end
                end else if (hz) begin
                    if (LOAD_LAT > 1) begin
                        st_nxt  = LSTALL;
                        cnt_nxt = LOAD_LD;
                    end else begin
                        resolve = 1'b1;
                    end
                end else begin
                    pc_i    = 1'b1;
                    ifid_i  = 1'b1;
                    bub_i   = 1'b0;
                    resolve = 1'b1;
                end
                if (resolve) begin
                    if (st == STEP || dbg_halt) begin
                        st_nxt  = HALT;
                        ret_nxt = 1'b0;
                    end else begin
                        st_nxt = RUN;
                    end
                end
            end
            FLUSH, LSTALL: begin
                if (st == FLUSH) begin
                    pc_i    = 1'b1;
                    flush_i = 1'b1;
                end
                if (cnt == 2'd0) begin
                    // A halt requested (or a step begun) during the stall takes effect here.
                    if (ret_flag || dbg_halt) begin
                        st_nxt  = HALT;
                        ret_nxt = 1'b0;
                    end else begin
                        st_nxt = RUN;
                    end
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            HALT: begin
                halt_i = 1'b1;
                if (step_rise) begin
                    st_nxt  = STEP;
                    ret_nxt = 1'b1;
                end else if (!dbg_halt) begin
                    st_nxt  = RUN;
                    ret_nxt = 1'b0;
                end
            end
            default: st_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= RUN;
            cnt        <= '0;
            ret_flag   <= 1'b0;
            dbg_step_q <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            st         <= st_nxt;
            cnt        <= cnt_nxt;
            ret_flag   <= ret_nxt;
            dbg_step_q <= dbg_step;
            if (!pc_i && st != HALT && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Reset forces the stage registers into a safe bubble/flush immediately.
    assign pc_en       = rst_n & pc_i;
    assign ifid_en     = rst_n & ifid_i;
    assign idex_bubble = ~rst_n | bub_i;
    assign ifid_flush  = ~rst_n | flush_i;
    assign halted      = rst_n & halt_i;
    assign state       = st;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: default build (LOAD_LAT=1,
// FLUSH_CYCLES=2) plus a LOAD_LAT=3 build sharing the same stimulus.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       idv, rau;
        logic [2:0] ra;
        logic       rbu;
        logic [2:0] rb;
        logic       spu, exv, we;
        logic [2:0] wa;
        logic       ld, spw, redir, halt, step;
    } in_t;

    typedef struct {
        string      tag;
        logic       pc, ifid, bub, fl, hlt;
        logic [2:0] st;
        logic [7:0] sc;
        logic       chk3;
        logic [2:0] st3;
        logic       pc3;
        logic [7:0] sc3;
    } exp_t;

    localparam int K_NORM = 0, K_STALL = 1, K_FLUSH = 2, K_HALT = 3;

    in_t  cur = '0;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       pc_en, ifid_en, idex_bubble, ifid_flush, halted;
    logic [2:0] state;
    logic [7:0] stall_cnt;
    logic       pc_en3, ifid_en3, idex_bubble3, ifid_flush3, halted3;
    logic [2:0] state3;
    logic [7:0] stall_cnt3;

    pipe_hazard_ctrl #(.RA_W(3), .LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(cur.idv), .id_ra_use(cur.rau), .id_ra(cur.ra),
        .id_rb_use(cur.rbu), .id_rb(cur.rb), .id_sp_use(cur.spu),
        .ex_valid(cur.exv), .ex_we(cur.we), .ex_wa(cur.wa), .ex_load(cur.ld),
        .ex_sp_wr(cur.spw), .ex_redirect(cur.redir),
        .dbg_halt(cur.halt), .dbg_step(cur.step),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .halted(halted), .state(state), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.RA_W(3), .LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .id_valid(cur.idv), .id_ra_use(cur.rau), .id_ra(cur.ra),
        .id_rb_use(cur.rbu), .id_rb(cur.rb), .id_sp_use(cur.spu),
        .ex_valid(cur.exv), .ex_we(cur.we), .ex_wa(cur.wa), .ex_load(cur.ld),
        .ex_sp_wr(cur.spw), .ex_redirect(cur.redir),
        .dbg_halt(cur.halt), .dbg_step(cur.step),
        .pc_en(pc_en3), .ifid_en(ifid_en3), .idex_bubble(idex_bubble3),
        .ifid_flush(ifid_flush3), .halted(halted3), .state(state3), .stall_cnt(stall_cnt3)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input string tag, input int kind, input logic [2:0] st,
                                input logic [7:0] sc);
        exp_t e;
        e.tag = tag; e.st = st; e.sc = sc; e.hlt = 1'b0;
        e.chk3 = 1'b0; e.st3 = 3'd0; e.pc3 = 1'b0; e.sc3 = 8'd0;
        case (kind)
            K_NORM:  begin e.pc = 1; e.ifid = 1; e.bub = 0; e.fl = 0; end
            K_STALL: begin e.pc = 0; e.ifid = 0; e.bub = 1; e.fl = 0; end
            K_FLUSH: begin e.pc = 1; e.ifid = 0; e.bub = 1; e.fl = 1; end
            default: begin e.pc = 0; e.ifid = 0; e.bub = 1; e.fl = 0; e.hlt = 1; end
        endcase
        return e;
    endfunction

    function automatic exp_t with3(input exp_t e, input logic [2:0] st3, input logic pc3,
                                   input logic [7:0] sc3);
        exp_t r = e;
        r.chk3 = 1'b1; r.st3 = st3; r.pc3 = pc3; r.sc3 = sc3;
        return r;
    endfunction

    function automatic in_t ld_use(input logic [2:0] ra, input logic ld);
        in_t i = '0;
        i.idv = 1; i.rau = 1; i.ra = ra;
        i.exv = 1; i.we = 1; i.wa = 3'd3; i.ld = ld;
        return i;
    endfunction

    function automatic in_t dbg(input logic h, input logic s, input logic r);
        in_t i = '0;
        i.halt = h; i.step = s; i.redir = r;
        return i;
    endfunction

    // Drive one cycle's inputs just after the edge and queue what must be seen.
    task automatic tick(input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        cur = i;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq({e.tag, ".pc_en"},       32'(pc_en),       32'(e.pc));
            check_eq({e.tag, ".ifid_en"},     32'(ifid_en),     32'(e.ifid));
            check_eq({e.tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e.bub));
            check_eq({e.tag, ".ifid_flush"},  32'(ifid_flush),  32'(e.fl));
            check_eq({e.tag, ".halted"},      32'(halted),      32'(e.hlt));
            check_eq({e.tag, ".state"},       32'(state),       32'(e.st));
            check_eq({e.tag, ".stall_cnt"},   32'(stall_cnt),   32'(e.sc));
            if (e.chk3) begin
                check_eq({e.tag, ".ll3_state"}, 32'(state3),     32'(e.st3));
                check_eq({e.tag, ".ll3_pc_en"}, 32'(pc_en3),     32'(e.pc3));
                check_eq({e.tag, ".ll3_stall"}, 32'(stall_cnt3), 32'(e.sc3));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".pc_en"},       32'(pc_en),       32'd0);
        check_eq({tag, ".ifid_en"},     32'(ifid_en),     32'd0);
        check_eq({tag, ".idex_bubble"}, 32'(idex_bubble), 32'd1);
        check_eq({tag, ".ifid_flush"},  32'(ifid_flush),  32'd1);
        check_eq({tag, ".halted"},      32'(halted),      32'd0);
        check_eq({tag, ".state"},       32'(state),       32'd0);
        check_eq({tag, ".stall_cnt"},   32'(stall_cnt),   32'd0);
    endtask

    initial begin
        in_t spi;
        spi = '0;
        spi.idv = 1; spi.spu = 1; spi.exv = 1; spi.spw = 1;

        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on both builds; LOAD_LAT=3 gives states 0,1,1,0.
        tick('0,                with3(mk("idle0",   K_NORM,  3'd0, 8'd0), 3'd0, 1'b1, 8'd0));
        tick(ld_use(3'd3, 1'b1), with3(mk("ldhz",    K_STALL, 3'd0, 8'd0), 3'd0, 1'b0, 8'd0));
        tick('0,                with3(mk("ldhz+1",  K_NORM,  3'd0, 8'd1), 3'd1, 1'b0, 8'd1));
        tick('0,                with3(mk("ldhz+2",  K_NORM,  3'd0, 8'd1), 3'd1, 1'b0, 8'd2));
        tick('0,                with3(mk("ldhz+3",  K_NORM,  3'd0, 8'd1), 3'd0, 1'b1, 8'd3));

        tick(ld_use(3'd4, 1'b1), mk("ld_nomatch", K_NORM,  3'd0, 8'd1));
        tick(ld_use(3'd3, 1'b0), mk("alu_wr",     K_NORM,  3'd0, 8'd1));
        tick(spi,                mk("sp_hz",      K_STALL, 3'd0, 8'd1));
        tick('0,                 mk("sp_hz+1",    K_NORM,  3'd0, 8'd2));

        // Redirect with a simultaneous load-use hazard: hazard ignored.
        begin
            in_t r;
            r = ld_use(3'd3, 1'b1);
            r.redir = 1'b1;
            tick(r, mk("redir", K_FLUSH, 3'd0, 8'd2));
        end
        tick('0, mk("redir+1", K_FLUSH, 3'd2, 8'd2));
        tick('0, mk("redir+2", K_NORM,  3'd0, 8'd2));

        // Halt, single step, release.
        tick(dbg(1, 0, 0), mk("halt_req", K_NORM, 3'd0, 8'd2));
        tick(dbg(1, 0, 0), mk("halted1",  K_HALT, 3'd3, 8'd2));
        tick(dbg(1, 0, 0), mk("halted2",  K_HALT, 3'd3, 8'd2));
        tick(dbg(1, 1, 0), mk("step_rise", K_HALT, 3'd3, 8'd2));
        tick(dbg(1, 1, 0), mk("step",     K_NORM, 3'd4, 8'd2));
        tick(dbg(1, 1, 0), mk("step_held", K_HALT, 3'd3, 8'd2));
        tick(dbg(1, 0, 0), mk("step_low", K_HALT, 3'd3, 8'd2));

        // Step that hits a redirect: one FLUSH cycle, then back to HALT.
        tick(dbg(1, 1, 0), mk("step2_rise", K_HALT, 3'd3, 8'd2));
        begin
            exp_t e;
            e = mk("step2_redir", K_FLUSH, 3'd4, 8'd2);
            tick(dbg(1, 0, 1), e);
        end
        tick(dbg(0, 0, 0), mk("step2_flush", K_FLUSH, 3'd2, 8'd2));
        tick(dbg(0, 0, 0), mk("back_halt",   K_HALT,  3'd3, 8'd2));
        tick('0,           mk("resume",      K_NORM,  3'd0, 8'd2));

        // Reset mid-FLUSH.
        tick(dbg(0, 0, 1), mk("redir2",   K_FLUSH, 3'd0, 8'd2));
        tick('0,           mk("redir2+1", K_FLUSH, 3'd2, 8'd2));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_midflush");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick('0, mk("post_rst", K_NORM, 3'd0, 8'd0));

        begin
            int budget;
            budget = 10;
            while (sb.size() != 0 && budget > 0) begin
                @(negedge clk);
                #1;
                budget--;
            end
        end
        check_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
